mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 3, cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 10, word-address width of the internal storage (2^ADDR_BITS 16-bit words).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_address  in  16  byte address (lc3b_word); bit 0 ignored; bits [ADDR_BITS:1] select the word.
REQ-006 mem_read  in  1  read request, held high by the initiator until mem_resp.
REQ-007 mem_write  in  1  write request, held high by the initiator until mem_resp.
REQ-008 mem_byte_enable  in  2  write byte mask (lc3b_mem_wmask): bit1 = [15:8], bit0 = [7:0].
REQ-009 mem_wdata  in  16  write data.
REQ-010 mem_rdata  out  16  read data; valid in the mem_resp cycle of a read.
REQ-011 mem_resp  out  1  single-cycle completion pulse.
REQ-012 protocol_error  out  1  sticky flag for illegal request encodings.

Function
REQ-013 States: IDLE, BUSY, RESP.
REQ-014 In IDLE, a cycle with mem_read or mem_write high accepts the request and latches the word address, byte mask, wdata and op; transition to BUSY, counter loaded with LATENCY-1.
REQ-015 LATENCY = 1 goes IDLE -> RESP directly.
REQ-016 BUSY decrements the counter each cycle and enters RESP when the counter reaches 1.
REQ-017 For a request first high in cycle N, mem_resp is high in cycle N+LATENCY only; it is low in every other cycle.
REQ-018 Reads: mem_rdata equals storage[latched address] throughout the RESP cycle. Outside RESP it holds its previous value.
REQ-019 Writes commit at the rising edge ending the RESP cycle. Only bytes with mem_byte_enable = 1 are updated; the mask 2'b00 writes nothing.
REQ-020 RESP -> IDLE unconditionally.
REQ-021 A request still high in the IDLE cycle after RESP is treated as a new request; back-to-back requests are therefore separated by at least one IDLE cycle.
REQ-022 Abort: if mem_read and mem_write are both low during BUSY, return to IDLE with no resp and no write.
REQ-023 Request inputs other than the read/write level are ignored after acceptance; changes to the address, mask or data during BUSY have no effect.
REQ-024 mem_read and mem_write both high at acceptance sets protocol_error, which holds until reset. The request is serviced as a write.
REQ-025 Storage is not initialised by reset. Bench preload is done via the storage sub-module only.

Reset
REQ-026 rst_n low forces, asynchronously: state IDLE, counter 0, mem_resp 0, mem_rdata 16'h0000, protocol_error 0.
REQ-027 Reset asserted during BUSY or RESP cancels the in-flight request; no storage write occurs.
REQ-028 The first request can be accepted in the first clock cycle after rst_n deasserts.

Structure
REQ-029 lc3b_word and lc3b_mem_wmask come from lc3b_types.
REQ-030 A responder state enum and the default latency constant are added to lc3b_types.
REQ-031 One sub-module, mem_array: synchronous byte-masked write, combinational read, no reset.
REQ-032 Target size: 150-250 lines RTL.

Verification
REQ-033 Read latency: preload word 0x0010 = 16'hBEEF, LATENCY=3; hold mem_read with address 16'h0020 from cycle 0 -> mem_resp only in cycle 3, with mem_rdata = 16'hBEEF.
REQ-034 Byte write: word 0x0010 = 16'hBEEF; write 16'h1234 with mask 2'b01 -> resp after 3 cycles; a following read returns 16'hBE34. With mask 2'b10 instead -> 16'h12EF.
REQ-035 Abort: drop mem_write in cycle 1 of a LATENCY=3 write -> no mem_resp in cycles 1-6, storage unchanged.
REQ-036 Back-to-back: hold mem_read across resp -> second mem_resp in cycle 3+1+3 = 7, with no resp in between.
REQ-037 Illegal encoding: mem_read = mem_write = 1 -> protocol_error = 1 and the write is committed; the flag stays 1 until rst_n pulses low.
REQ-038 Reset mid-op: assert rst_n low during BUSY of a write -> mem_resp = 0 immediately and a later read shows the old data.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b memory-side types.
//   lc3b_word          16-bit data / byte address
//   lc3b_mem_wmask     2-bit write byte mask (bit1 = [15:8], bit0 = [7:0])
//   responder_state_t  state of the mem_responder request FSM
//   DEFAULT_LATENCY    default request-to-response latency in cycles
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_BUSY = 2'd1,
        RSP_RESP = 2'd2
    } responder_state_t;

    localparam int DEFAULT_LATENCY = 3;

endpackage

// File: rtl/mem_array.sv
// mem_array: word-organised storage with byte-masked writes.
//   clk    in   write clock
//   we     in   write enable, commits at the rising edge
//   addr   in   word index (read and write share it)
//   be     in   byte mask, bit1 = [15:8], bit0 = [7:0]
//   wdata  in   write data
//   rdata  out  combinational read of mem[addr]
// Contents are deliberately not reset.
module mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  lc3b_mem_wmask        be,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    lc3b_word mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory model for an LC-3b style initiator.
//   clk              in   clock
//   rst_n            in   asynchronous active-low reset
//   mem_address      in   byte address, bits [ADDR_BITS:1] select the word
//   mem_read         in   read request level, held until mem_resp
//   mem_write        in   write request level, held until mem_resp
//   mem_byte_enable  in   write byte mask
//   mem_wdata        in   write data
//   mem_rdata        out  read data, valid in the mem_resp cycle of a read
//   mem_resp         out  one-cycle completion pulse
//   protocol_error   out  sticky: read and write were both high at acceptance
//   dbg_state        out  current FSM state
//
// Handshake: a request is accepted in any IDLE cycle where mem_read or
// mem_write is high; the initiator keeps the level high until it sees
// mem_resp, which arrives exactly LATENCY cycles after the first high cycle.
// Dropping both levels while BUSY aborts the request silently. LATENCY must
// be 1..15.
module mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int ADDR_BITS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  lc3b_word         mem_address,
    input  logic             mem_read,
    input  logic             mem_write,
    input  lc3b_mem_wmask    mem_byte_enable,
    input  lc3b_word         mem_wdata,
    output lc3b_word         mem_rdata,
    output logic             mem_resp,
    output logic             protocol_error,
    output responder_state_t dbg_state
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    responder_state_t     state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 accept;
    logic                 req_any;

    logic [ADDR_BITS-1:0] addr_q;
    lc3b_mem_wmask        be_q;
    lc3b_word             wdata_q;
    logic                 op_write_q;
    logic                 perr_q;
    lc3b_word             rdata_q;
    lc3b_word             arr_rdata;
    logic                 arr_we;

    // Only part of the byte address selects a word; fold the whole bus here
    // so the discarded bits are visibly intentional.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address;

    assign req_any = mem_read | mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            RSP_IDLE: begin
                if (req_any) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RSP_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = RSP_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            RSP_BUSY: begin
                // Abort takes priority even on the last BUSY cycle.
                if (!req_any) begin
                    state_d = RSP_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RSP_RESP;
                end
            end
            RSP_RESP: begin
                state_d = RSP_IDLE;
            end
            default: begin
                state_d = RSP_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RSP_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            be_q       <= 2'b00;
            wdata_q    <= 16'h0000;
            op_write_q <= 1'b0;
            perr_q     <= 1'b0;
            rdata_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= mem_rdata;
            if (accept) begin
                addr_q     <= mem_address[ADDR_BITS:1];
                be_q       <= mem_byte_enable;
                wdata_q    <= mem_wdata;
                // Read+write together is illegal; it is serviced as a write.
                op_write_q <= mem_write;
                if (mem_read && mem_write) perr_q <= 1'b1;
            end
        end
    end

    // The write is qualified by the registered state, so an asynchronous
    // reset during RESP forces IDLE before the edge and suppresses it.
    assign mem_resp       = (state_q == RSP_RESP);
    assign arr_we         = mem_resp && op_write_q;
    assign mem_rdata      = (mem_resp && !op_write_q) ? arr_rdata : rdata_q;
    assign protocol_error = perr_q;
    assign dbg_state      = state_q;

    mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (addr_q),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import lc3b_types::*;

  localparam int LAT   = 3;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]      mem_address = 16'h0;
  logic             mem_read = 1'b0;
  logic             mem_write = 1'b0;
  logic [1:0]       mem_byte_enable = 2'b00;
  logic [15:0]      mem_wdata = 16'h0;
  logic [15:0]      mem_rdata;
  logic             mem_resp;
  logic             protocol_error;
  responder_state_t dbg_state;

  mem_responder #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .protocol_error  (protocol_error),
    .dbg_state       (dbg_state)
  );

  // scoreboard
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] exp_q [$];
  logic [15:0] last_rd = 16'h0000;

  function automatic int widx(input logic [15:0] a);
    return int'(a[AB:1]);
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd);
    int i;
    i = widx(a);
    if (be[0]) model[i][7:0] = wd[7:0];
    if (be[1]) model[i][15:8] = wd[15:8];
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    dut.u_array.mem[widx(a)] = v;
    model[widx(a)] = v;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_rd = 16'h0000;
    exp_q.delete();
  endtask

  // One request held until mem_resp, then one idle cycle checked.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [1:0] be, input logic [15:0] wd, input string name);
    int c;
    bit got;
    logic [15:0] e;
    if (rd && !wr) exp_q.push_back(model[widx(a)]);
    mem_read = rd;
    mem_write = wr;
    mem_address = a;
    mem_byte_enable = be;
    mem_wdata = wd;
    got = 0;
    c = 0;
    while (!got && c <= LAT + 4) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        got = 1;
        n_tests++;
        if (c != LAT) begin
          n_fail++;
          $display("FAIL %s resp_cycle: got %0d expected %0d", name, c, LAT);
        end
        n_tests++;
        if (rd && !wr) begin
          e = exp_q.pop_front();
          if (mem_rdata !== e) begin
            n_fail++;
            $display("FAIL %s rdata: got %h expected %h", name, mem_rdata, e);
          end
          last_rd = e;
        end else if (mem_rdata !== last_rd) begin
          n_fail++;
          $display("FAIL %s rdata_hold_on_write: got %h expected %h", name, mem_rdata, last_rd);
        end
      end
      @(posedge clk);
      if (got && wr) model_write(a, be, wd);
      #1;
      if (got) idle_inputs();
      else if (c == 0) begin
        // After acceptance these must be ignored.
        mem_address = 16'($urandom);
        mem_byte_enable = 2'($urandom);
        mem_wdata = 16'($urandom);
      end
      c++;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no resp within %0d cycles, expected at %0d", name, LAT + 5, LAT);
      exp_q.delete();
      idle_inputs();
    end
    @(negedge clk);
    n_tests++;
    if (mem_resp !== 1'b0 || mem_rdata !== last_rd) begin
      n_fail++;
      $display("FAIL %s idle_after: resp=%b rdata=%h expected resp=0 rdata=%h",
               name, mem_resp, mem_rdata, last_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000 || protocol_error !== 1'b0 ||
        dbg_state !== RSP_IDLE) begin
      n_fail++;
      $display("FAIL reset_values: resp=%b rdata=%h perr=%b state=%0d expected 0/0000/0/IDLE",
               mem_resp, mem_rdata, protocol_error, dbg_state);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Request raised in the first cycle after reset release.
  task automatic test_read_latency();
    preload(16'h0020, 16'hBEEF);
    txn(1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, "read_latency");
    n_tests++;
    if (last_rd !== 16'hBEEF || mem_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL read_beef: got %h expected beef", mem_rdata);
    end
  endtask

  task automatic test_byte_write();
    logic [1:0] masks [3];
    logic [15:0] want [3];
    masks[0] = 2'b01; want[0] = 16'hBE34;
    masks[1] = 2'b10; want[1] = 16'h12EF;
    masks[2] = 2'b00; want[2] = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      preload(16'h0020, 16'hBEEF);
      txn(1'b0, 1'b1, 16'h0020, masks[k], 16'h1234, "byte_write");
      txn(1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, "byte_readback");
      n_tests++;
      if (mem_rdata !== want[k]) begin
        n_fail++;
        $display("FAIL byte_mask_%b: got %h expected %h", masks[k], mem_rdata, want[k]);
      end
    end
  endtask

  task automatic test_abort();
    for (int drop = 1; drop < LAT; drop++) begin
      preload(16'h0044, 16'h5A5A);
      mem_write = 1'b1;
      mem_address = 16'h0044;
      mem_byte_enable = 2'b11;
      mem_wdata = 16'hDEAD;
      for (int c = 0; c <= 6; c++) begin
        if (c == drop) idle_inputs();
        @(negedge clk);
        if (c >= 1) begin
          n_tests++;
          if (mem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drop%0d cycle%0d: resp=%b expected 0", drop, c, mem_resp);
          end
        end
        @(posedge clk);
        #1;
      end
      txn(1'b1, 1'b0, 16'h0044, 2'b00, 16'h0000, "abort_readback");
    end
  endtask

  task automatic test_back_to_back();
    bit want;
    preload(16'h0066, 16'hC0DE);
    mem_read = 1'b1;
    mem_address = 16'h0066;
    for (int c = 0; c <= 9; c++) begin
      want = (c == LAT) || (c == 2 * LAT + 1);
      @(negedge clk);
      n_tests++;
      if (mem_resp !== want) begin
        n_fail++;
        $display("FAIL b2b cycle%0d: resp=%b expected %b", c, mem_resp, want);
      end
      if (want) begin
        n_tests++;
        if (mem_rdata !== 16'hC0DE) begin
          n_fail++;
          $display("FAIL b2b rdata cycle%0d: got %h expected c0de", c, mem_rdata);
        end
        last_rd = 16'hC0DE;
      end
      @(posedge clk);
      #1;
      if (c == 2 * LAT + 1) idle_inputs();
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] wd;
    logic [1:0] be;
    bit is_wr;
    for (int k = 0; k < 40; k++) begin
      a = 16'($urandom);
      a[AB:5] = '0;
      wd = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      is_wr = 1'($urandom_range(0, 1));
      txn(!is_wr, is_wr, a, be, wd, "random");
    end
  endtask

  task automatic test_protocol_error();
    txn(1'b1, 1'b1, 16'h0088, 2'b11, 16'hA55A, "perr_write");
    n_tests++;
    if (protocol_error !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_set: got %b expected 1", protocol_error);
    end
    txn(1'b1, 1'b0, 16'h0088, 2'b00, 16'h0000, "perr_readback");
    n_tests++;
    if (mem_rdata !== 16'hA55A || protocol_error !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_sticky: rdata=%h perr=%b expected a55a/1", mem_rdata, protocol_error);
    end
    reset_pulse();
    @(negedge clk);
    n_tests++;
    if (protocol_error !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_clear: got %b expected 0", protocol_error);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    preload(16'h00AA, 16'h1111);
    txn(1'b1, 1'b0, 16'h00AA, 2'b00, 16'h0000, "midop_preread");
    for (int at = 1; at <= LAT; at++) begin
      mem_write = 1'b1;
      mem_address = 16'h00AA;
      mem_byte_enable = 2'b11;
      mem_wdata = 16'h9999;
      repeat (at) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_tests++;
      if (mem_resp !== 1'b0 || dbg_state !== RSP_IDLE || mem_rdata !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_midop_at%0d: resp=%b state=%0d rdata=%h expected 0/IDLE/0000",
                 at, mem_resp, dbg_state, mem_rdata);
      end
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      last_rd = 16'h0000;
      exp_q.delete();
      txn(1'b1, 1'b0, 16'h00AA, 2'b00, 16'h0000, "midop_readback");
      n_tests++;
      if (mem_rdata !== 16'h1111) begin
        n_fail++;
        $display("FAIL midop_old_data_at%0d: got %h expected 1111", at, mem_rdata);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 16'($urandom);
      dut.u_array.mem[i] = model[i];
    end
    repeat (2) @(posedge clk);
    test_reset();
    test_read_latency();
    test_byte_write();
    test_abort();
    test_back_to_back();
    test_random();
    test_protocol_error();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
